// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner with tick-based press/release debounce.
// Optional auto-repeat while held is enabled by defining KEY_REPEAT_EN.
module keypad_scan #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int SCAN_FREQ = 1000,
  parameter int DEB_TICKS = 20
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [3:0] key_row_in,
  output logic [3:0] key_col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pressed
);

  localparam int TICK_PERIOD = CLK_FREQ / SCAN_FREQ;
  localparam int TW = $clog2(TICK_PERIOD);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_PERIOD - 1);
  localparam logic [7:0] DEB_LAST = 8'(DEB_TICKS);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS_DEB = 3'd1,
    SCAN      = 3'd2,
    HIT       = 3'd3,
    HELD      = 3'd4,
    REL_DEB   = 3'd5
  } state_t;

  logic [3:0]    row_meta_q, row_sync_q;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  state_t        state_q, state_d;
  logic [7:0]    deb_cnt_q, deb_cnt_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    col_out_q, col_out_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          pressed_q, pressed_d;
  logic          tick, row_idle;
`ifdef KEY_REPEAT_EN
  logic [8:0]    rep_cnt_q, rep_cnt_d;
  logic          rep_first_q, rep_first_d;
  logic [8:0]    rep_target;
`endif

  function automatic logic [1:0] lowest_zero(input logic [3:0] row);
    logic [1:0] idx;
    if (!row[0])      idx = 2'd0;
    else if (!row[1]) idx = 2'd1;
    else if (!row[2]) idx = 2'd2;
    else              idx = 2'd3;
    return idx;
  endfunction

  assign tick     = (tick_cnt_q == TICK_LAST);
  assign row_idle = (row_sync_q == 4'hF);

  // Rows are asynchronous to sys_clk; two flops before any decision is made.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= key_row_in;
      row_sync_q <= row_meta_q;
    end
  end

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    state_d    = state_q;
    deb_cnt_d  = deb_cnt_q;
    col_d      = col_q;
    code_d     = code_q;
    valid_d    = 1'b0;
    pressed_d  = pressed_q;
`ifdef KEY_REPEAT_EN
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    rep_target  = rep_first_q ? 9'd500 : 9'd100;
`endif
    case (state_q)
      IDLE: begin
        if (tick && !row_idle) begin
          deb_cnt_d = 8'd0;
          state_d   = PRESS_DEB;
        end else begin
          state_d = IDLE;
        end
      end
      PRESS_DEB: begin
        if (!tick) begin
          state_d = PRESS_DEB;
        end else if (row_idle) begin
          state_d = IDLE;
        end else if (deb_cnt_q + 8'd1 == DEB_LAST) begin
          deb_cnt_d = deb_cnt_q + 8'd1;
          col_d     = 2'd0;
          state_d   = SCAN;
        end else begin
          deb_cnt_d = deb_cnt_q + 8'd1;
        end
      end
      SCAN: begin
        // The lowest column reaches a hit first, so it wins over higher ones.
        if (!tick) begin
          state_d = SCAN;
        end else if (!row_idle) begin
          code_d    = {lowest_zero(row_sync_q), col_q};
          valid_d   = 1'b1;
          pressed_d = 1'b1;
          state_d   = HIT;
        end else if (col_q == 2'd3) begin
          state_d = IDLE;
        end else begin
          col_d = col_q + 2'd1;
        end
      end
      HIT: begin
        state_d = HELD;
`ifdef KEY_REPEAT_EN
        rep_cnt_d   = 9'd0;
        rep_first_d = 1'b1;
`endif
      end
      HELD: begin
        if (tick && row_idle) begin
          deb_cnt_d = 8'd0;
          state_d   = REL_DEB;
        end else if (tick) begin
`ifdef KEY_REPEAT_EN
          if (rep_cnt_q + 9'd1 == rep_target) begin
            valid_d     = 1'b1;
            rep_cnt_d   = 9'd0;
            rep_first_d = 1'b0;
          end else begin
            rep_cnt_d = rep_cnt_q + 9'd1;
          end
`else
          state_d = HELD;
`endif
        end else begin
          state_d = HELD;
        end
      end
      REL_DEB: begin
        if (!tick) begin
          state_d = REL_DEB;
        end else if (!row_idle) begin
          state_d = HELD;
`ifdef KEY_REPEAT_EN
          rep_cnt_d   = 9'd0;
          rep_first_d = 1'b1;
`endif
        end else if (deb_cnt_q + 8'd1 == DEB_LAST) begin
          deb_cnt_d = deb_cnt_q + 8'd1;
          pressed_d = 1'b0;
          state_d   = IDLE;
        end else begin
          deb_cnt_d = deb_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    case (state_d)
      SCAN, HIT: col_out_d = ~(4'b0001 << col_d);
      default:   col_out_d = 4'b0000;
    endcase
  end

  // Column drive is registered from the next state so it changes with the state.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tick_cnt_q <= '0;
      state_q    <= IDLE;
      deb_cnt_q  <= 8'd0;
      col_q      <= 2'd0;
      col_out_q  <= 4'b0000;
      code_q     <= 4'd0;
      valid_q    <= 1'b0;
      pressed_q  <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_cnt_q   <= 9'd0;
      rep_first_q <= 1'b1;
`endif
    end else begin
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      deb_cnt_q  <= deb_cnt_d;
      col_q      <= col_d;
      col_out_q  <= col_out_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      pressed_q  <= pressed_d;
`ifdef KEY_REPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
`endif
    end
  end

  assign key_col_out = col_out_q;
  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_pressed = pressed_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: a matrix model drives rows from the
// column drive; expected codes come from a key-priority model.
module tb_keypad_scan;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [3:0]  key_row_in;
  logic [3:0]  key_col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_pressed;
  logic [15:0] keys;          // bit r*4+c set = key at row r, column c held
  int          checks = 0;
  int          errors = 0;
  int          strobes = 0;

  always #5 sys_clk = ~sys_clk;

  keypad_scan #(.CLK_FREQ(1000), .SCAN_FREQ(100), .DEB_TICKS(3)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .key_row_in(key_row_in),
    .key_col_out(key_col_out), .key_code(key_code), .key_valid(key_valid),
    .key_pressed(key_pressed)
  );

  // A held key pulls its row low whenever its column is driven low.
  always_comb begin
    key_row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !key_col_out[c]) key_row_in[r] = 1'b0;
  end

  always @(negedge sys_clk) if (key_valid === 1'b1) strobes++;

  // Scan order is column-major, so the first held key in that order wins.
  function automatic logic [3:0] exp_code(input logic [15:0] mask);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (mask[r*4+c]) return 4'(r*4 + c);
    return 4'd0;
  endfunction

  task automatic cycle();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_strobe(input int limit, output int lat);
    int base;
    base = strobes;
    lat = 0;
    while (strobes == base && lat < limit) begin
      cycle();
      lat++;
    end
  endtask

  task automatic wait_col(input logic [3:0] pat, input int limit, output logic found);
    int n;
    n = 0;
    found = (key_col_out === pat);
    while (!found && n < limit) begin
      cycle();
      n++;
      found = (key_col_out === pat);
    end
  endtask

  initial begin : stim
    int lat;
    int base;
    logic found;
    logic [15:0] mask;
    int nk;

    sys_rst = 1'b1;
    keys = 16'h0000;
    cycle();
    cycle();
    check("rst_col", 32'(key_col_out), 32'h0);
    check("rst_code", 32'(key_code), 32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_pressed", 32'(key_pressed), 32'h0);
    sys_rst = 1'b0;
    repeat (200) cycle();
    check("idle_strobes", 32'(strobes), 32'h0);
    check("idle_col", 32'(key_col_out), 32'h0);

    // Single key row2/col1.
    base = strobes;
    keys = 16'h0001 << 9;
    wait_strobe(100, lat);
    check("k9_latency_ok", 32'(lat >= 52 && lat <= 63), 32'h1);
    check("k9_valid", 32'(key_valid), 32'h1);
    check("k9_code", 32'(key_code), 32'h9);
    check("k9_pressed", 32'(key_pressed), 32'h1);
    check("k9_hit_col", 32'(key_col_out), 32'hD);
    cycle();
    check("k9_valid_one_cycle", 32'(key_valid), 32'h0);
    check("k9_held_col", 32'(key_col_out), 32'h0);
    repeat (100) cycle();
    check("k9_single_strobe", 32'(strobes), 32'(base + 1));
    check("k9_pressed_held", 32'(key_pressed), 32'h1);
    keys = 16'h0000;
    repeat (20) cycle();
    check("k9_release_deb_hold", 32'(key_pressed), 32'h1);
    repeat (40) cycle();
    check("k9_released", 32'(key_pressed), 32'h0);
    check("k9_code_kept", 32'(key_code), 32'h9);
    check("k9_no_release_strobe", 32'(strobes), 32'(base + 1));

    // Short bounce on row0 never completes the press debounce.
    base = strobes;
    keys = 16'h0001;
    repeat ($urandom_range(11, 25)) cycle();
    keys = 16'h0000;
    repeat (80) cycle();
    check("bounce_no_strobe", 32'(strobes), 32'(base));
    check("bounce_pressed", 32'(key_pressed), 32'h0);

    // Two keys together: col0/row3 beats col2/row1.
    base = strobes;
    keys = (16'h0001 << 12) | (16'h0001 << 6);
    wait_strobe(150, lat);
    check("multi_strobe_seen", 32'(lat < 150), 32'h1);
    repeat (100) cycle();
    check("multi_code", 32'(key_code), 32'hC);
    check("multi_single_strobe", 32'(strobes), 32'(base + 1));
    keys = 16'h0000;
    repeat (60) cycle();
    check("multi_released", 32'(key_pressed), 32'h0);

    // Key col3/row0 released as its column scan begins.
    base = strobes;
    keys = 16'h0001 << 3;
    wait_col(4'b0111, 200, found);
    check("midscan_col3_reached", 32'(found), 32'h1);
    keys = 16'h0000;
    repeat (40) cycle();
    check("midscan_no_strobe", 32'(strobes), 32'(base));
    check("midscan_idle_col", 32'(key_col_out), 32'h0);
    check("midscan_pressed", 32'(key_pressed), 32'h0);
    keys = 16'h0001 << 3;
    wait_strobe(150, lat);
    check("k3_latency_ok", 32'(lat >= 72 && lat <= 83), 32'h1);
    check("k3_code", 32'(key_code), 32'h3);
    repeat (30) cycle();
    keys = 16'h0000;
    repeat (60) cycle();
    check("k3_single_strobe", 32'(strobes), 32'(base + 1));

    // Reset in the middle of a scan.
    base = strobes;
    keys = 16'h0001 << 6;
    wait_col(4'b1110, 150, found);
    check("rstscan_scan_reached", 32'(found), 32'h1);
    sys_rst = 1'b1;
    cycle();
    check("rstscan_col", 32'(key_col_out), 32'h0);
    check("rstscan_code", 32'(key_code), 32'h0);
    check("rstscan_valid", 32'(key_valid), 32'h0);
    check("rstscan_pressed", 32'(key_pressed), 32'h0);
    keys = 16'h0000;
    sys_rst = 1'b0;
    repeat (100) cycle();
    check("rstscan_no_strobe", 32'(strobes), 32'(base));

    // Random key combinations against the priority model.
    for (int it = 0; it < 10; it++) begin
      mask = 16'h0000;
      nk = $urandom_range(1, 3);
      for (int k = 0; k < nk; k++) mask[$urandom_range(0, 15)] = 1'b1;
      base = strobes;
      keys = mask;
      wait_strobe(150, lat);
      check($sformatf("rand%0d_seen", it), 32'(lat < 150), 32'h1);
      check($sformatf("rand%0d_code", it), 32'(key_code), 32'(exp_code(mask)));
      check($sformatf("rand%0d_pressed", it), 32'(key_pressed), 32'h1);
      repeat (50) cycle();
      check($sformatf("rand%0d_single", it), 32'(strobes), 32'(base + 1));
      keys = 16'h0000;
      repeat (60) cycle();
      check($sformatf("rand%0d_released", it), 32'(key_pressed), 32'h0);
      repeat ($urandom_range(0, 20)) cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
